// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and the baud divisor helper used by TX (and a future RX)
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;
  function automatic int calc_divisor(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..DIVISOR-1 counter (clk, reset, clr in; bit_tick out on last clock of each bit)
module uart_baud_tick #(
  parameter int DIVISOR = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_tick
);
  localparam int W = $clog2(DIVISOR);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_tick = cnt_q == W'(DIVISOR - 1);
  always_comb cnt_d = (clr || bit_tick) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter (clk, reset, tx_start, tx_data[7:0] in; tx_busy, tx_done, tx out)
module uart_tx import uart_pkg::*; #(
  parameter int          CLK_FREQ  = 100_000_000,
  parameter int          BAUD_RATE = 115_200,
  parameter logic [1:0]  PARITY    = 2'd0,
  parameter int          STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);
  localparam int      DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam parity_t PAR     = parity_t'(PARITY);
  if (DIVISOR < 2) begin : g_bad_div
    $error("uart_tx: DIVISOR must be at least 2");
  end
  if (PARITY == 2'd3) begin : g_bad_par
    $error("uart_tx: PARITY=3 is illegal");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept, bit_tick;
  assign accept = state_q == S_IDLE && tx_start;
  uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .bit_tick (bit_tick)
  );
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    case (state_q)
      S_IDLE: if (tx_start) begin
        state_d    = S_START;
        shift_d    = tx_data;
        par_d      = PAR == PAR_ODD ? ~^tx_data : ^tx_data;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
      end
      S_START:  if (bit_tick) state_d = S_DATA;
      S_DATA: if (bit_tick) begin
        shift_d   = shift_q >> 1;
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = PAR == PAR_NONE ? S_STOP : S_PARITY;
      end
      S_PARITY: if (bit_tick) state_d = S_STOP;
      S_STOP: if (bit_tick) begin
        stop_idx_d = stop_idx_q + 1'b1;
        if (stop_idx_q == 1'(STOP_BITS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    tx_d   = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : state_d == S_PARITY ? par_d : 1'b1;
    busy_d = state_d != S_IDLE;
    done_d = state_q == S_STOP && state_d == S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx configurations checked against a frame-level reference model and receiver
module tb_uart_tx;
  localparam int DIV = 10;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] st = '0;
  logic [7:0] tx_data = '0;
  logic [3:0] tx_w, busy_w, done_w;
  int         pm[4] = '{0, 1, 2, 0};
  int         sb[4] = '{1, 1, 1, 2};
  int         errors = 0;
  int         checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .CLK_FREQ  (1_000_000),
      .BAUD_RATE (100_000),
      .PARITY    (g == 1 ? 2'd1 : g == 2 ? 2'd2 : 2'd0),
      .STOP_BITS (g == 3 ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .tx_start (st[g]),
      .tx_data  (tx_data),
      .tx_busy  (busy_w[g]),
      .tx_done  (done_w[g]),
      .tx       (tx_w[g])
    );
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int frame_len(input int i);
    return (9 + (pm[i] != 0 ? 1 : 0) + sb[i]) * DIV;
  endfunction
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && pm[i] == 1) return ^d;
    if (k == 9 && pm[i] == 2) return ~^d;
    return 1'b1;
  endfunction
  task automatic start(input int i, input logic [7:0] d);
    st[i] = 1'b1;
    tx_data = d;
  endtask
  task automatic check_frame(input int i, input logic [7:0] d, input bit inj, input bit chain, input logic [7:0] nd);
    logic [7:0] rx = '0;
    int len = frame_len(i);
    @(negedge clk);
    st[i] = 1'b0;
    for (int c = 0; c < len; c++) begin
      if (inj && c == 40) begin
        st[i] = 1'b1;
        tx_data = 8'h3C;
      end else begin
        st[i] = 1'b0;
        if (c == 20) tx_data = 8'($urandom);
      end
      chk($sformatf("d%0d tx c=%0d", i, c), {7'd0, tx_w[i]}, {7'd0, exp_bit(i, d, c / DIV)});
      chk($sformatf("d%0d busy c=%0d", i, c), {7'd0, busy_w[i]}, 8'd1);
      if (c % DIV == DIV / 2 && c / DIV >= 1 && c / DIV <= 8) rx[c/DIV-1] = tx_w[i];
      if (c % DIV == 0) chk($sformatf("d%0d done c=%0d", i, c), {7'd0, done_w[i]}, 8'd0);
      @(negedge clk);
    end
    st[i] = 1'b0;
    chk($sformatf("d%0d busy end", i), {7'd0, busy_w[i]}, 8'd0);
    chk($sformatf("d%0d done end", i), {7'd0, done_w[i]}, 8'd1);
    chk($sformatf("d%0d idle tx", i), {7'd0, tx_w[i]}, 8'd1);
    chk($sformatf("d%0d rx byte", i), rx, d);
    if (chain) start(i, nd);
    else begin
      @(negedge clk);
      chk($sformatf("d%0d done drop", i), {7'd0, done_w[i]}, 8'd0);
      chk($sformatf("d%0d tx idle", i), {7'd0, tx_w[i]}, 8'd1);
    end
  endtask
  initial begin
    logic [7:0] d, d2;
    int i;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset tx", {4'd0, tx_w}, 8'h0F);
    chk("reset busy", {4'd0, busy_w}, 8'h00);
    chk("reset done", {4'd0, done_w}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      start(k, 8'hA5);
      check_frame(k, 8'hA5, 1'b0, 1'b0, 8'h00);
    end
    start(0, 8'hA5);
    check_frame(0, 8'hA5, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k += 3) begin
      start(k, 8'h00);
      check_frame(k, 8'h00, 1'b0, 1'b1, 8'hFF);
      check_frame(k, 8'hFF, 1'b0, 1'b0, 8'h00);
    end
    start(0, 8'hC3);
    @(negedge clk);
    st[0] = 1'b0;
    repeat (54) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort tx", {7'd0, tx_w[0]}, 8'd1);
    chk("abort busy", {7'd0, busy_w[0]}, 8'd0);
    chk("abort done", {7'd0, done_w[0]}, 8'd0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c % 10 == 0) chk($sformatf("abort quiet c=%0d", c), {4'd0, done_w | busy_w}, 8'h00);
    end
    start(0, 8'h5A);
    check_frame(0, 8'h5A, 1'b0, 1'b0, 8'h00);
    start(3, 8'h81);
    check_frame(3, 8'h81, 1'b0, 1'b0, 8'h00);
    repeat (8) begin
      i = $urandom_range(0, 3);
      d = 8'($urandom);
      d2 = 8'($urandom);
      start(i, d);
      if ($urandom_range(0, 1) == 1) begin
        check_frame(i, d, 1'b0, 1'b1, d2);
        check_frame(i, d2, 1'b0, 1'b0, 8'h00);
      end else check_frame(i, d, $urandom_range(0, 1) == 1, 1'b0, 8'h00);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
